// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for a 5-stage RV32I pipeline (IF, DI, EX, ME, WB).
// Keeps a shadow scoreboard of the destination registers that currently sit
// in the EX, ME and WB slots. From that scoreboard it generates:
//   - load-use stalls (PC / IF-DI hold plus a bubble into DI/EX),
//   - taken-branch flushes (branch resolved in ME, 3-cycle penalty),
//   - EX-stage operand forwarding selects,
//   - DI-stage write-back bypass selects,
//   - saturating stall / flush event counters for performance debug.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RESET_N      synchronous active-low reset
//   ID_RS1/RS2   source register fields of the instruction in DI
//   ID_USE_RS1/2 DI instruction actually reads rs1 / rs2
//   ID_RD        destination register field of the DI instruction
//   ID_REGWRITE  DI instruction writes the register bank
//   ID_MEMREAD   DI instruction is a load
//   BRANCH_TAKEN branch taken, resolved in ME
//   CNT_CLR      synchronous clear of both event counters
//   PC_EN        PC update enable
//   IFID_EN      IF/DI register load enable
//   IFID_FLUSH   load NOP into IF/DI
//   IDEX_FLUSH   bubble into DI/EX
//   EXME_FLUSH   bubble into EX/ME
//   FWD_A/FWD_B  ALU operand source: 00 DI/EX, 01 EX/ME ALU result, 10 WB mux
//   FWD_ID_A/B   DI read data taken from the WB mux output
//   STALL_CNT    saturating count of load-use stall cycles
//   FLUSH_CNT    saturating count of taken-branch flush cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [REG_W-1:0] ID_RS1,
  input  logic [REG_W-1:0] ID_RS2,
  input  logic             ID_USE_RS1,
  input  logic             ID_USE_RS2,
  input  logic [REG_W-1:0] ID_RD,
  input  logic             ID_REGWRITE,
  input  logic             ID_MEMREAD,
  input  logic             BRANCH_TAKEN,
  input  logic             CNT_CLR,
  output logic             PC_EN,
  output logic             IFID_EN,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic             EXME_FLUSH,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             FWD_ID_A,
  output logic             FWD_ID_B,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  // Forwarding source encoding shared by FWD_A and FWD_B.
  typedef enum logic [1:0] {
    FWD_SRC_REG  = 2'b00,
    FWD_SRC_EXME = 2'b01,
    FWD_SRC_WB   = 2'b10
  } fwd_src_e;

  // Destination information tracked for every in-flight instruction.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } dest_t;

  localparam dest_t BUBBLE = '{rd: '0, regwrite: 1'b0, memread: 1'b0};

  dest_t            ex_slot;
  dest_t            me_slot;
  dest_t            wb_slot;
  dest_t            id_dest;

  // Source registers of the EX instruction. An unused source is stored as
  // x0 so that it can never trigger a forward.
  logic [REG_W-1:0] ex_rs1;
  logic [REG_W-1:0] ex_rs2;
  logic [REG_W-1:0] id_rs1_used;
  logic [REG_W-1:0] id_rs2_used;

  logic             load_use;
  logic             stall;
  logic             flush;

  // x0 is hard-wired to zero, so a write to it never produces a dependency.
  function automatic logic reg_match(input dest_t slot, input logic [REG_W-1:0] rs);
    return slot.regwrite && (slot.rd == rs) && (rs != '0);
  endfunction

  // ME carries the newest value, so it wins over WB. A load in ME has no
  // data yet; the stall keeps that case from arising, so it simply falls
  // through to the WB check.
  function automatic fwd_src_e ex_fwd_sel(input dest_t me, input dest_t wb,
                                          input logic [REG_W-1:0] rs);
    if (reg_match(me, rs) && !me.memread) begin
      return FWD_SRC_EXME;
    end else if (reg_match(wb, rs)) begin
      return FWD_SRC_WB;
    end else begin
      return FWD_SRC_REG;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == '1) begin
      return value;
    end else begin
      return value + CNT_W'(1);
    end
  endfunction

  assign id_dest.rd       = ID_RD;
  assign id_dest.regwrite = ID_REGWRITE;
  assign id_dest.memread  = ID_MEMREAD;
  assign id_rs1_used      = ID_USE_RS1 ? ID_RS1 : '0;
  assign id_rs2_used      = ID_USE_RS2 ? ID_RS2 : '0;

  // A load in EX whose result is needed by the DI instruction costs one
  // cycle. A taken branch squashes the younger stalling instruction anyway,
  // so the flush suppresses the stall.
  assign load_use = ex_slot.memread &&
                    ((ID_USE_RS1 && reg_match(ex_slot, ID_RS1)) ||
                     (ID_USE_RS2 && reg_match(ex_slot, ID_RS2)));
  assign flush    = BRANCH_TAKEN;
  assign stall    = load_use && !flush;

  always_comb begin
    PC_EN      = 1'b1;
    IFID_EN    = 1'b1;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    EXME_FLUSH = 1'b0;
    if (flush) begin
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
      EXME_FLUSH = 1'b1;
    end else if (stall) begin
      PC_EN      = 1'b0;
      IFID_EN    = 1'b0;
      IDEX_FLUSH = 1'b1;
    end
  end

  always_comb begin
    FWD_A    = ex_fwd_sel(me_slot, wb_slot, ex_rs1);
    FWD_B    = ex_fwd_sel(me_slot, wb_slot, ex_rs2);
    // Register bank writes and reads in the same cycle; bypass the WB value.
    FWD_ID_A = ID_USE_RS1 && reg_match(wb_slot, ID_RS1);
    FWD_ID_B = ID_USE_RS2 && reg_match(wb_slot, ID_RS2);
  end

  // Scoreboard shifts along with the pipeline registers. Flushed or stalled
  // positions become bubbles so they cannot cause forwards or stalls later.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ex_slot <= BUBBLE;
      me_slot <= BUBBLE;
      wb_slot <= BUBBLE;
      ex_rs1  <= '0;
      ex_rs2  <= '0;
    end else begin
      wb_slot <= me_slot;
      me_slot <= flush ? BUBBLE : ex_slot;
      if (flush || stall) begin
        ex_slot <= BUBBLE;
        ex_rs1  <= '0;
        ex_rs2  <= '0;
      end else begin
        ex_slot <= id_dest;
        ex_rs1  <= id_rs1_used;
        ex_rs2  <= id_rs2_used;
      end
    end
  end

  // Clear wins over a same-cycle event; counts stick at all-ones.
  always_ff @(posedge CLK) begin
    if (!RESET_N || CNT_CLR) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (stall) begin
        STALL_CNT <= sat_inc(STALL_CNT);
      end
      if (flush) begin
        FLUSH_CNT <= sat_inc(FLUSH_CNT);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. A reference model keeps the in-flight
// instructions as a queue (front = EX, back = WB) and derives every expected
// output from the hazard rules. Directed scenarios are followed by a random
// phase and a counter saturation run.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RESET_N;
  logic [REG_W-1:0] ID_RS1;
  logic [REG_W-1:0] ID_RS2;
  logic             ID_USE_RS1;
  logic             ID_USE_RS2;
  logic [REG_W-1:0] ID_RD;
  logic             ID_REGWRITE;
  logic             ID_MEMREAD;
  logic             BRANCH_TAKEN;
  logic             CNT_CLR;
  logic             PC_EN;
  logic             IFID_EN;
  logic             IFID_FLUSH;
  logic             IDEX_FLUSH;
  logic             EXME_FLUSH;
  logic [1:0]       FWD_A;
  logic [1:0]       FWD_B;
  logic             FWD_ID_A;
  logic             FWD_ID_B;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .ID_RS1      (ID_RS1),
    .ID_RS2      (ID_RS2),
    .ID_USE_RS1  (ID_USE_RS1),
    .ID_USE_RS2  (ID_USE_RS2),
    .ID_RD       (ID_RD),
    .ID_REGWRITE (ID_REGWRITE),
    .ID_MEMREAD  (ID_MEMREAD),
    .BRANCH_TAKEN(BRANCH_TAKEN),
    .CNT_CLR     (CNT_CLR),
    .PC_EN       (PC_EN),
    .IFID_EN     (IFID_EN),
    .IFID_FLUSH  (IFID_FLUSH),
    .IDEX_FLUSH  (IDEX_FLUSH),
    .EXME_FLUSH  (EXME_FLUSH),
    .FWD_A       (FWD_A),
    .FWD_B       (FWD_B),
    .FWD_ID_A    (FWD_ID_A),
    .FWD_ID_B    (FWD_ID_B),
    .STALL_CNT   (STALL_CNT),
    .FLUSH_CNT   (FLUSH_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: one record per in-flight instruction.
  typedef struct {
    int rd;
    bit writes;
    bit loads;
    int src1;
    int src2;
  } instr_t;

  instr_t pipe[$];
  int     stall_total;
  int     flush_total;

  function automatic instr_t nop_instr();
    instr_t n;
    n.rd = 0; n.writes = 0; n.loads = 0; n.src1 = 0; n.src2 = 0;
    return n;
  endfunction

  function automatic bit depends(instr_t producer, int rs);
    return producer.writes && rs != 0 && producer.rd == rs;
  endfunction

  function automatic bit exp_stall();
    bit needs;
    needs = (ID_USE_RS1 && depends(pipe[0], int'(ID_RS1))) ||
            (ID_USE_RS2 && depends(pipe[0], int'(ID_RS2)));
    return !BRANCH_TAKEN && pipe[0].loads && needs;
  endfunction

  function automatic int exp_fwd(int rs);
    if (depends(pipe[1], rs) && !pipe[1].loads) return 1;
    if (depends(pipe[2], rs)) return 2;
    return 0;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pipe.delete();
    repeat (3) pipe.push_back(nop_instr());
    stall_total = 0;
    flush_total = 0;
  endtask

  // Advance the model by one clock using the inputs held across that edge.
  task automatic modelUpdate();
    instr_t incoming;
    bit     st;
    if (!RESET_N) begin
      modelReset();
      return;
    end
    st = exp_stall();
    if (CNT_CLR) begin
      stall_total = 0;
      flush_total = 0;
    end else begin
      if (st && stall_total < CNT_MAX) stall_total++;
      if (BRANCH_TAKEN && flush_total < CNT_MAX) flush_total++;
    end
    incoming.rd     = int'(ID_RD);
    incoming.writes = ID_REGWRITE;
    incoming.loads  = ID_MEMREAD;
    incoming.src1   = ID_USE_RS1 ? int'(ID_RS1) : 0;
    incoming.src2   = ID_USE_RS2 ? int'(ID_RS2) : 0;
    if (BRANCH_TAKEN || st) incoming = nop_instr();
    if (BRANCH_TAKEN) pipe[0] = nop_instr();
    void'(pipe.pop_back());
    pipe.push_front(incoming);
  endtask

  task automatic checkOutput();
    bit st;
    st = exp_stall();
    checkVal("pc_en",      PC_EN,      !st);
    checkVal("ifid_en",    IFID_EN,    !st);
    checkVal("ifid_flush", IFID_FLUSH, BRANCH_TAKEN);
    checkVal("idex_flush", IDEX_FLUSH, BRANCH_TAKEN || st);
    checkVal("exme_flush", EXME_FLUSH, BRANCH_TAKEN);
    checkVal("fwd_a",      FWD_A,      exp_fwd(pipe[0].src1));
    checkVal("fwd_b",      FWD_B,      exp_fwd(pipe[0].src2));
    checkVal("fwd_id_a",   FWD_ID_A,   ID_USE_RS1 && depends(pipe[2], int'(ID_RS1)));
    checkVal("fwd_id_b",   FWD_ID_B,   ID_USE_RS2 && depends(pipe[2], int'(ID_RS2)));
    checkVal("stall_cnt",  STALL_CNT,  stall_total);
    checkVal("flush_cnt",  FLUSH_CNT,  flush_total);
    // A load in ME feeding EX must have been prevented by the stall.
    checkVal("no_load_in_me_dep",
             pipe[1].loads && (depends(pipe[1], pipe[0].src1) || depends(pipe[1], pipe[0].src2)),
             0);
  endtask

  // Clock the previous inputs in, then drive new ones mid-cycle and check.
  task automatic applyStimulus(input bit rst_n, input int rs1, input int rs2,
                               input bit use1, input bit use2, input int rd,
                               input bit rw, input bit mr, input bit br, input bit clr);
    @(posedge CLK);
    modelUpdate();
    @(negedge CLK);
    RESET_N      = rst_n;
    ID_RS1       = REG_W'(rs1);
    ID_RS2       = REG_W'(rs2);
    ID_USE_RS1   = use1;
    ID_USE_RS2   = use2;
    ID_RD        = REG_W'(rd);
    ID_REGWRITE  = rw;
    ID_MEMREAD   = mr;
    BRANCH_TAKEN = br;
    CNT_CLR      = clr;
    #1;
    checkOutput();
  endtask

  task automatic nop();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    RESET_N = 1'b0; ID_RS1 = '0; ID_RS2 = '0; ID_USE_RS1 = 1'b0; ID_USE_RS2 = 1'b0;
    ID_RD = '0; ID_REGWRITE = 1'b0; ID_MEMREAD = 1'b0; BRANCH_TAKEN = 1'b0; CNT_CLR = 1'b0;
    modelReset();

    // Reset held for two cycles with all inputs low.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("rst_pc_en", PC_EN, 1);
    checkVal("rst_ifid_en", IFID_EN, 1);
    checkVal("rst_flushes", {IFID_FLUSH, IDEX_FLUSH, EXME_FLUSH}, 0);
    checkVal("rst_fwd", {FWD_A, FWD_B}, 0);
    checkVal("rst_cnts", {STALL_CNT, FLUSH_CNT}, 0);

    // lw x5,0(x1) ; add x6,x5,x2 -> one stall, then WB forward.
    applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    applyStimulus(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
    checkVal("lu_pc_en", PC_EN, 0);
    checkVal("lu_ifid_en", IFID_EN, 0);
    checkVal("lu_idex_flush", IDEX_FLUSH, 1);
    applyStimulus(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
    checkVal("lu_released", PC_EN, 1);
    nop();
    checkVal("lu_fwd_a_wb", FWD_A, 2);
    checkVal("lu_stall_cnt", STALL_CNT, 1);

    // add x3,x1,x2 ; sub x4,x3,x3 -> forward from EX/ME.
    applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    applyStimulus(1, 3, 3, 1, 1, 4, 1, 0, 0, 0);
    checkVal("alu_no_stall", PC_EN, 1);
    nop();
    checkVal("alu_fwd_me", {FWD_A, FWD_B}, 4'b0101);

    // Same pair with an independent instruction between -> forward from WB.
    applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    applyStimulus(1, 1, 2, 1, 1, 9, 1, 0, 0, 0);
    applyStimulus(1, 3, 3, 1, 1, 4, 1, 0, 0, 0);
    nop();
    checkVal("alu_fwd_wb", {FWD_A, FWD_B}, 4'b1010);

    // addi x0,x0,5 ; add x7,x0,x0 -> x0 never forwards.
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 7, 1, 0, 0, 0);
    nop();
    checkVal("x0_fwd", {FWD_A, FWD_B}, 0);
    applyStimulus(1, 0, 0, 1, 1, 7, 1, 0, 0, 0);
    checkVal("x0_fwd_id_a", FWD_ID_A, 0);

    // WB bypass into DI: producer two slots ahead.
    applyStimulus(1, 1, 2, 1, 1, 12, 1, 0, 0, 0);
    nop();
    nop();
    applyStimulus(1, 12, 12, 1, 1, 13, 1, 0, 0, 0);
    checkVal("id_bypass", {FWD_ID_A, FWD_ID_B}, 2'b11);

    // Branch taken in the same cycle as a load-use hazard.
    applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    applyStimulus(1, 5, 2, 1, 1, 6, 1, 0, 1, 0);
    checkVal("br_flushes", {IFID_FLUSH, IDEX_FLUSH, EXME_FLUSH}, 3'b111);
    checkVal("br_pc_en", {PC_EN, IFID_EN}, 2'b11);
    applyStimulus(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
    checkVal("br_stall_cnt", STALL_CNT, 1);
    checkVal("br_flush_cnt", FLUSH_CNT, 1);
    checkVal("br_ex_bubble", PC_EN, 1);

    // Reset during a load-use stall.
    applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    applyStimulus(0, 5, 2, 1, 1, 6, 1, 0, 0, 0);
    applyStimulus(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
    checkVal("rst_mid_stall", {PC_EN, IDEX_FLUSH}, 2'b10);
    checkVal("rst_mid_cnt", STALL_CNT, 0);

    // Random phase: small register range so hazards are frequent.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 63) != 0,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                    int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 31) == 0);
    end

    // Saturation: clear, then more branches than the counter can hold.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    checkVal("flush_sat", FLUSH_CNT, 16'hFFFF);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkVal("flush_sat_hold", FLUSH_CNT, 16'hFFFF);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop();
    checkVal("clr_over_event", FLUSH_CNT, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
